// File: rtl/riscboy_ppu_mem_responder.sv
// PPU fetch-bus responder: serves byte/halfword/word reads from a 1-cycle SRAM with lane replication.
// Optional one-word read buffer enabled by defining PPU_MEM_RESPONDER_BUF_EN.
module riscboy_ppu_mem_responder #(
    parameter int W_ADDR      = 32,
    parameter int W_DATA      = 32,
    parameter int W_SRAM_ADDR = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   bus_vld,
    input  logic [W_ADDR-1:0]      bus_addr,
    input  logic [1:0]             bus_size,
    output logic                   bus_rdy,
    output logic [W_DATA-1:0]      bus_data,
    output logic                   sram_ren,
    output logic [W_SRAM_ADDR-1:0] sram_addr,
    input  logic [31:0]            sram_rdata,
    input  logic [3:0]             cfg_wait_states,
    input  logic                   inval,
    output logic                   err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]  state;
    logic [3:0]  wait_cnt;
    logic [31:0] word;
    logic [1:0]  req_off;
    logic [1:0]  req_size;
    logic        req_err;
    logic        req_err_now;
    logic        hit;
    logic [31:0] hit_data;
    logic        unused_bits;

    // Misaligned halfword/word and the reserved size code all count as protocol errors.
    assign req_err_now = (bus_size == 2'd3)
                      || (bus_size == 2'd1 && bus_addr[0])
                      || (bus_size == 2'd2 && bus_addr[1:0] != 2'b00);

    assign sram_addr = bus_addr[W_SRAM_ADDR+1:2];
    assign sram_ren  = (state == S_IDLE) && bus_vld && !hit;
    assign bus_rdy   = (state == S_RESP);

    function automatic logic [W_DATA-1:0] lane_replicate(
        input logic [31:0] w,
        input logic [1:0]  off,
        input logic [1:0]  size,
        input logic        bad
    );
        logic [31:0] b_sh;
        logic [31:0] h_sh;
        logic [31:0] res;
        b_sh = w >> {off, 3'b000};
        h_sh = w >> {off[1], 4'b0000};
        case (size)
            2'd0:    res = {4{b_sh[7:0]}};
            2'd1:    res = {2{h_sh[15:0]}};
            2'd2:    res = w;
            default: res = 32'd0;
        endcase
        if (bad) res = 32'd0;
        return res;
    endfunction

`ifdef PPU_MEM_RESPONDER_BUF_EN
    logic                   buf_vld;
    logic [W_SRAM_ADDR-1:0] buf_tag;
    logic [31:0]            buf_data;
    logic [W_SRAM_ADDR-1:0] req_tag;

    assign hit = buf_vld && !inval && !req_err_now && (buf_tag == bus_addr[W_SRAM_ADDR+1:2]);
    assign hit_data = buf_data;
    assign unused_bits = ^bus_addr[W_ADDR-1:W_SRAM_ADDR+2];

    // Invalidate wins over fill, so an inval during READ or WAIT leaves the buffer empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_vld  <= 1'b0;
            buf_tag  <= '0;
            buf_data <= '0;
            req_tag  <= '0;
        end else begin
            if (state == S_IDLE && bus_vld)
                req_tag <= bus_addr[W_SRAM_ADDR+1:2];
            if (inval)
                buf_vld <= 1'b0;
            else if (state == S_READ && !req_err) begin
                buf_vld  <= 1'b1;
                buf_tag  <= req_tag;
                buf_data <= sram_rdata;
            end
        end
    end
`else
    assign hit = 1'b0;
    assign hit_data = 32'd0;
    assign unused_bits = ^{bus_addr[W_ADDR-1:W_SRAM_ADDR+2], inval};
`endif

    // Request attributes are latched at issue so a misbehaving initiator cannot corrupt the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            word     <= '0;
            req_off  <= '0;
            req_size <= '0;
            req_err  <= 1'b0;
            bus_data <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus_vld) begin
                        req_off  <= bus_addr[1:0];
                        req_size <= bus_size;
                        req_err  <= req_err_now;
                        if (req_err_now)
                            err <= 1'b1;
                        if (hit) begin
                            bus_data <= lane_replicate(hit_data, bus_addr[1:0], bus_size, 1'b0);
                            state    <= S_RESP;
                        end else begin
                            wait_cnt <= cfg_wait_states;
                            state    <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    word <= sram_rdata;
                    if (wait_cnt != 4'd0) begin
                        state <= S_WAIT;
                    end else begin
                        bus_data <= lane_replicate(sram_rdata, req_off, req_size, req_err);
                        state    <= S_RESP;
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt <= 4'd1) begin
                        bus_data <= lane_replicate(word, req_off, req_size, req_err);
                        state    <= S_RESP;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscboy_ppu_mem_responder.sv
// Directed self-checking bench for riscboy_ppu_mem_responder with a behavioural 1-cycle SRAM.
module tb_riscboy_ppu_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bus_vld = 1'b0;
    logic [31:0] bus_addr = '0;
    logic [1:0]  bus_size = '0;
    logic        bus_rdy;
    logic [31:0] bus_data;
    logic        sram_ren;
    logic [13:0] sram_addr;
    logic [31:0] sram_rdata = '0;
    logic [3:0]  cfg_wait_states = '0;
    logic        inval = 1'b0;
    logic        err;

    logic [31:0] mem [0:15];
    int checks = 0;
    int errors = 0;

    riscboy_ppu_mem_responder dut (
        .clk(clk), .rst(rst), .bus_vld(bus_vld), .bus_addr(bus_addr), .bus_size(bus_size),
        .bus_rdy(bus_rdy), .bus_data(bus_data), .sram_ren(sram_ren), .sram_addr(sram_addr),
        .sram_rdata(sram_rdata), .cfg_wait_states(cfg_wait_states), .inval(inval), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_ren)
            sram_rdata <= (sram_addr[13:4] == 10'd4) ? mem[sram_addr[3:0]] : 32'hDEAD_BEEF;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 with the DUT back in IDLE.
    task automatic applyStimulus(input logic [31:0] addr, input logic [1:0] size,
                                 output int lat, output logic [31:0] data,
                                 output logic ren_t, output logic [13:0] ren_addr);
        bus_vld  = 1'b1;
        bus_addr = addr;
        bus_size = size;
        #1;
        ren_t    = sram_ren;
        ren_addr = sram_addr;
        lat  = -1;
        data = 'x;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (bus_rdy) begin
                lat  = c;
                data = bus_data;
                break;
            end
        end
        bus_vld = 1'b0;
        if (lat < 0)
            checkOutput("timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          lat;
        logic [31:0] data;
        logic        ren;
        logic [13:0] raddr;
        logic        acc;

        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[0] = 32'hDDCCBBAA;
        mem[1] = 32'h44332211;
        mem[3] = 32'h8899AABB;
        mem[4] = 32'h55667788;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        acc = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 acc = acc | bus_rdy | sram_ren | err;
        end
        checkOutput("idle_quiet", {31'd0, acc}, 32'd0);
        checkOutput("idle_err", {31'd0, err}, 32'd0);

        applyStimulus(32'h100, 2'd2, lat, data, ren, raddr);
        checkOutput("w100_ren", {31'd0, ren}, 32'd1);
        checkOutput("w100_addr", {18'd0, raddr}, 32'h40);
        checkOutput("w100_lat", lat, 32'd2);
        checkOutput("w100_data", data, 32'hDDCCBBAA);

        applyStimulus(32'h101, 2'd0, lat, data, ren, raddr);
        checkOutput("b101", data, 32'hBBBBBBBB);
        applyStimulus(32'h102, 2'd0, lat, data, ren, raddr);
        checkOutput("b102", data, 32'hCCCCCCCC);
        applyStimulus(32'h103, 2'd0, lat, data, ren, raddr);
        checkOutput("b103", data, 32'hDDDDDDDD);
        applyStimulus(32'h102, 2'd1, lat, data, ren, raddr);
        checkOutput("h102", data, 32'hDDCCDDCC);
        checkOutput("h102_err", {31'd0, err}, 32'd0);

        // Wait-state change at T+3 must not shorten the in-flight response.
        cfg_wait_states = 4'd5;
        fork
            applyStimulus(32'h10C, 2'd2, lat, data, ren, raddr);
            begin
                repeat (3) @(posedge clk);
                #1 cfg_wait_states = 4'd0;
            end
        join
        checkOutput("ws5_lat", lat, 32'd7);
        checkOutput("ws5_data", data, 32'h8899AABB);

        applyStimulus(32'h101, 2'd1, lat, data, ren, raddr);
        checkOutput("herr_lat", lat, 32'd2);
        checkOutput("herr_data", data, 32'd0);
        checkOutput("herr_flag", {31'd0, err}, 32'd1);
        for (int i = 0; i < 100; i++)
            applyStimulus(32'h100 + i % 4, 2'd0, lat, data, ren, raddr);
        checkOutput("err_sticky", {31'd0, err}, 32'd1);
        checkOutput("after100_data", data, 32'hDDDDDDDD);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("err_cleared", {31'd0, err}, 32'd0);

        applyStimulus(32'h104, 2'd0, lat, data, ren, raddr);
        checkOutput("b104_lat", lat, 32'd2);
        checkOutput("b104_data", data, 32'h11111111);
        applyStimulus(32'h105, 2'd0, lat, data, ren, raddr);
        checkOutput("b105_data", data, 32'h22222222);
`ifdef PPU_MEM_RESPONDER_BUF_EN
        checkOutput("b105_hit_lat", lat, 32'd1);
        checkOutput("b105_hit_ren", {31'd0, ren}, 32'd0);
`else
        checkOutput("b105_lat", lat, 32'd2);
        checkOutput("b105_ren", {31'd0, ren}, 32'd1);
`endif
        inval = 1'b1;
        @(posedge clk);
        #1 inval = 1'b0;
        applyStimulus(32'h105, 2'd0, lat, data, ren, raddr);
        checkOutput("inval_ren", {31'd0, ren}, 32'd1);
        checkOutput("inval_lat", lat, 32'd2);
        checkOutput("inval_data", data, 32'h22222222);

        // Reset lands in WAIT at T+3 with four wait states; the response must be dropped.
        cfg_wait_states = 4'd4;
        bus_vld  = 1'b1;
        bus_addr = 32'h110;
        bus_size = 2'd2;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        bus_vld = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        cfg_wait_states = 4'd0;
        acc = bus_rdy | sram_ren | err;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 acc = acc | bus_rdy;
        end
        checkOutput("rst_drop", {31'd0, acc}, 32'd0);
        applyStimulus(32'h100, 2'd2, lat, data, ren, raddr);
        checkOutput("post_rst_ren", {31'd0, ren}, 32'd1);
        checkOutput("post_rst_lat", lat, 32'd2);
        checkOutput("post_rst_data", data, 32'hDDCCBBAA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
